// File: rtl/idli_pkg.sv
// Shared types for the predicate datapath: predicate index, compare opcodes
// and the compare-unit FSM states.
package idli_pkg;

   typedef logic [1:0] preg_t;

   typedef enum logic [1:0] {
      CMP_EQ  = 2'b00,
      CMP_NE  = 2'b01,
      CMP_LTU = 2'b10,
      CMP_LT  = 2'b11
   } cmp_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_WB   = 2'b10
   } cmp_state_t;

   // P3 reads as constant true; writes to it are dropped.
   localparam preg_t PREG_TRUE = 2'd3;

   // Map final accumulator values onto the predicate value for an op.
   function automatic logic cmp_result(input cmp_op_t op, input logic eq, input logic lt);
      logic res;
      res = 1'b0;
      case (op)
         CMP_EQ:  res = eq;
         CMP_NE:  res = ~eq;
         CMP_LTU: res = lt;
         CMP_LT:  res = lt;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/idli_cmp_m_if.sv
// Serial operand / predicate write bundle between the datapath, the compare
// unit and the predicate register file write port.
interface idli_cmp_m_if;
   import idli_pkg::*;

   logic    i_cmp_start;
   cmp_op_t i_cmp_op;
   preg_t   i_cmp_dst;
   logic    i_cmp_a;
   logic    i_cmp_b;
   logic    o_cmp_busy;
   logic    o_cmp_wr_en;
   preg_t   o_cmp_wr_pred;
   logic    o_cmp_wr_data;

   modport master (
      output i_cmp_start, i_cmp_op, i_cmp_dst, i_cmp_a, i_cmp_b,
      input  o_cmp_busy, o_cmp_wr_en, o_cmp_wr_pred, o_cmp_wr_data
   );

   modport slave (
      input  i_cmp_start, i_cmp_op, i_cmp_dst, i_cmp_a, i_cmp_b,
      output o_cmp_busy, o_cmp_wr_en, o_cmp_wr_pred, o_cmp_wr_data
   );

endinterface

// File: rtl/idli_cmp_m.sv
// Bit-serial compare unit: folds two LSB-first operands over WIDTH cycles and
// issues a one-cycle predicate write with the EQ/NE/LTU/LT result.
module idli_cmp_m
   import idli_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input logic        i_cmp_gck,
   input logic        i_cmp_rst_n,
   idli_cmp_m_if.slave cmp
);

   localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   cmp_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   cmp_op_t          op_q;
   preg_t            dst_q;
   logic             eq_q;
   logic             lt_q;
   logic             busy_q;
   logic             wr_en_q;
   preg_t            wr_pred_q;
   logic             wr_data_q;

   logic bit_ne_c;
   logic eq_fin_c;
   logic lt_fin_c;
   logic res_c;

   // Final fold at the MSB: signed compare takes A's sign bit, unsigned takes B's.
   always_comb begin
      bit_ne_c = cmp.i_cmp_a ^ cmp.i_cmp_b;
      eq_fin_c = eq_q & ~bit_ne_c;
      lt_fin_c = lt_q;
      if (bit_ne_c) begin
         lt_fin_c = (op_q == CMP_LT) ? cmp.i_cmp_a : cmp.i_cmp_b;
      end
      res_c = cmp_result(op_q, eq_fin_c, lt_fin_c);
   end

   always_ff @(posedge i_cmp_gck or negedge i_cmp_rst_n) begin
      if (!i_cmp_rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= CMP_EQ;
         dst_q     <= '0;
         eq_q      <= 1'b1;
         lt_q      <= 1'b0;
         busy_q    <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_pred_q <= '0;
         wr_data_q <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         case (state_q)
            // WB accepts a start like IDLE so compares can run back to back.
            ST_IDLE, ST_WB: begin
               if (cmp.i_cmp_start) begin
                  op_q    <= cmp.i_cmp_op;
                  dst_q   <= cmp.i_cmp_dst;
                  eq_q    <= ~bit_ne_c;
                  lt_q    <= bit_ne_c & cmp.i_cmp_b;
                  cnt_q   <= CNT_W'(1);
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end else begin
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (cnt_q == CNT_LAST) begin
                  eq_q      <= eq_fin_c;
                  lt_q      <= lt_fin_c;
                  wr_en_q   <= (dst_q != PREG_TRUE);
                  wr_pred_q <= dst_q;
                  wr_data_q <= res_c;
                  cnt_q     <= '0;
                  busy_q    <= 1'b0;
                  state_q   <= ST_WB;
               end else begin
                  eq_q  <= eq_fin_c;
                  lt_q  <= bit_ne_c ? cmp.i_cmp_b : lt_q;
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               cnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmp.o_cmp_busy    = busy_q;
   assign cmp.o_cmp_wr_en   = wr_en_q;
   assign cmp.o_cmp_wr_pred = wr_pred_q;
   assign cmp.o_cmp_wr_data = wr_data_q;

endmodule
